// File: rtl/vec_fifo_to_sram_writer.sv
// Drains the s8 vector FIFO into scratchpad SRAM: one row per req/ack, base+stride addressing.
// Latency: a beat becomes a registered write in the next cycle. Backpressure: output_ready = ~mem_wr_valid | mem_wr_ready.
module vec_fifo_to_sram_writer #(
  parameter int VLEN   = 16,
  parameter int ADDR_W = 16,
  parameter int ROW_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic [ADDR_W-1:0]         cfg_row_stride,
  input  logic [ROW_W-1:0]          cfg_num_rows,
  input  logic [$clog2(VLEN)-1:0]   cfg_valid_cols,
  input  logic                      output_req,
  output logic                      req_ack,
  output logic [$clog2(VLEN)-1:0]   vec_valid_num_col,
  input  logic                      output_valid,
  output logic                      output_ready,
  input  logic [3:0]                output_mask,
  input  logic [31:0]               output_data,
  output logic                      mem_wr_valid,
  input  logic                      mem_wr_ready,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [31:0]               mem_wr_data,
  output logic [3:0]                mem_wr_strb,
  output logic                      busy,
  output logic                      done
);
  localparam int CW  = $clog2(VLEN);
  localparam int WPV = VLEN / 4;
  localparam int WW  = (WPV > 1) ? $clog2(WPV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REQ, S_ACK, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] stride_q;
  logic [ROW_W-1:0]  num_rows_q;
  logic [CW-1:0]     valid_cols_q;
  logic [ADDR_W-1:0] row_base;
  logic [ROW_W-1:0]  row_idx;
  logic [WW-1:0]     word_idx;
  logic              beat;
  logic              last_word;

  assign beat      = output_valid & output_ready;
  assign last_word = (word_idx == WW'(WPV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    output_ready = 1'b0;
    req_ack      = 1'b0;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (cfg_num_rows == '0) ? S_DONE : S_WAIT_REQ;
      end
      S_WAIT_REQ: begin
        if (output_req) state_nxt = S_ACK;
      end
      S_ACK: begin
        req_ack   = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        output_ready = ~mem_wr_valid | mem_wr_ready;
        // Leaving STREAM on the last beat keeps the upstream's trailing stale beat out.
        if (beat && last_word)
          state_nxt = ((row_idx + ROW_W'(1)) == num_rows_q) ? S_DRAIN : S_WAIT_REQ;
      end
      S_DRAIN: begin
        if (!mem_wr_valid || mem_wr_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q          <= '0;
      num_rows_q        <= '0;
      valid_cols_q      <= '0;
      row_base          <= '0;
      row_idx           <= '0;
      word_idx          <= '0;
      vec_valid_num_col <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        stride_q     <= cfg_row_stride;
        num_rows_q   <= cfg_num_rows;
        valid_cols_q <= cfg_valid_cols;
        row_base     <= cfg_base_addr;
        row_idx      <= '0;
        word_idx     <= '0;
      end
      if (state == S_WAIT_REQ && output_req) vec_valid_num_col <= valid_cols_q;
      if (beat) begin
        if (last_word) begin
          word_idx <= '0;
          row_idx  <= row_idx + ROW_W'(1);
          row_base <= row_base + stride_q;
        end else begin
          word_idx <= word_idx + WW'(1);
        end
      end
    end
  end

  // Single-entry write register; a drain and a reload in the same cycle is a back-to-back write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      mem_wr_strb  <= '0;
    end else begin
      if (mem_wr_valid && mem_wr_ready) mem_wr_valid <= 1'b0;
      if (beat && output_mask != 4'h0) begin
        mem_wr_valid <= 1'b1;
        mem_wr_addr  <= row_base + (ADDR_W'(word_idx) << 2);
        mem_wr_data  <= output_data;
        mem_wr_strb  <= output_mask;
      end
    end
  end
endmodule

// File: tb/tb_vec_fifo_to_sram_writer.sv
// Randomized bench: upstream FIFO driver, SRAM ready driver, and a write scoreboard monitor.
module tb_vec_fifo_to_sram_writer;
  localparam int VLEN = 16;
  localparam int AW   = 16;
  localparam int RW   = 8;
  localparam int WPV  = VLEN / 4;

  logic          clk, rst, start;
  logic [AW-1:0] cfg_base_addr, cfg_row_stride;
  logic [RW-1:0] cfg_num_rows;
  logic [3:0]    cfg_valid_cols;
  logic          output_req, req_ack;
  logic [3:0]    vec_valid_num_col;
  logic          output_valid, output_ready;
  logic [3:0]    output_mask;
  logic [31:0]   output_data;
  logic          mem_wr_valid, mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_wr_strb;
  logic          busy, done;

  vec_fifo_to_sram_writer #(.VLEN(VLEN), .ADDR_W(AW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_row_stride(cfg_row_stride),
    .cfg_num_rows(cfg_num_rows), .cfg_valid_cols(cfg_valid_cols),
    .output_req(output_req), .req_ack(req_ack), .vec_valid_num_col(vec_valid_num_col),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_mask(output_mask), .output_data(output_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } wr_t;

  wr_t sb[$];
  int  nvec = 0, nerr = 0;
  int  ack_cnt = 0, done_cnt = 0, busy_cnt = 0, wr_seen = 0, wr_base = 0;
  int  rdy_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req_ack, vec_valid_num_col, output_ready, mem_wr_valid,
                mem_wr_addr, mem_wr_data, mem_wr_strb, busy, done});
  endfunction

  // Monitor: samples on the falling edge, a write transfers at the next rising edge.
  logic       hold = 1'b0;
  logic [51:0] held;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (req_ack) ack_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("writes_done_before_done", 64'(sb.size()), 64'd0);
      end
      if (hold) chk("stall_hold_stable", {1'b1, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb},
                    {1'b1, 1'b1, held});
      if (mem_wr_valid && !mem_wr_ready) chk("output_ready_when_full", 64'(output_ready), 64'd0);
      if (mem_wr_valid && mem_wr_ready) begin
        wr_seen++;
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: got addr %0h data %0h strb %0h expected none",
                   mem_wr_addr, mem_wr_data, mem_wr_strb);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("sram_write", 64'({mem_wr_addr, mem_wr_data, mem_wr_strb}), 64'(e));
        end
      end
      hold = mem_wr_valid && !mem_wr_ready;
      held = {mem_wr_addr, mem_wr_data, mem_wr_strb};
    end
  end

  // SRAM ready driver; mode 2 holds ready low for 5 cycles on the job's second write.
  int stall = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: mem_wr_ready = 1'b1;
      1: mem_wr_ready = 1'($urandom_range(0, 1));
      2: begin
        if ((wr_seen - wr_base) == 1 && mem_wr_valid && stall < 5) begin
          mem_wr_ready = 1'b0;
          stall++;
        end else begin
          mem_wr_ready = 1'b1;
          if ((wr_seen - wr_base) == 0) stall = 0;
        end
      end
      default: mem_wr_ready = 1'b0;
    endcase
  end

  function automatic logic [3:0] pick_mask(input int pat, input int w);
    logic [3:0] m;
    m = 4'($urandom_range(0, 15));
    if (pat == 1) m = (w < 2) ? 4'hF : (w == 2) ? 4'h3 : 4'h0;
    if (pat == 2) m = (w < 3) ? 4'hF : 4'h7;
    return m;
  endfunction

  task automatic send_row(input int r, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input logic [3:0] vc, input int pat);
    bit got;
    logic [3:0]    m;
    logic [31:0]   d;
    logic [AW-1:0] a;
    output_req = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ack) begin got = 1; break; end
    end
    if (!got) begin timeout("req_ack"); output_req = 1'b0; return; end
    chk("vec_valid_num_col", 64'(vec_valid_num_col), 64'(vc));
    @(posedge clk); #1;
    output_req = 1'b0;
    for (int w = 0; w < WPV; w++) begin
      if (pat == 0 && $urandom_range(0, 3) == 0) begin
        output_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      m = pick_mask(pat, w);
      d = $urandom;
      output_valid = 1'b1;
      output_mask  = m;
      output_data  = d;
      a = base + stride * AW'(r) + AW'(4 * w);
      if (m != 4'h0) sb.push_back('{a, d, m});
      got = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        got = output_ready;
        @(posedge clk); #1;
        if (got) break;
      end
      if (!got) begin timeout("output_ready"); output_valid = 1'b0; return; end
    end
    // Upstream keeps valid up one extra cycle with stale data.
    output_data = 32'hDEADBEEF;
    output_mask = 4'hF;
    @(negedge clk);
    chk("output_ready_stale_beat", 64'(output_ready), 64'd0);
    @(posedge clk); #1;
    output_valid = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int rows,
                         input logic [3:0] vc, input int pat);
    int a0, b0, d0, lat;
    bit got;
    a0 = ack_cnt; b0 = busy_cnt; d0 = done_cnt;
    wr_base = wr_seen;
    cfg_base_addr = base; cfg_row_stride = stride; cfg_num_rows = RW'(rows); cfg_valid_cols = vc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base_addr = AW'($urandom); cfg_row_stride = AW'($urandom);
    cfg_num_rows = RW'($urandom); cfg_valid_cols = 4'($urandom);
    for (int r = 0; r < rows; r++) begin
      if (r == 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_row(r, base, stride, vc, pat);
    end
    got = 0; lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin got = 1; lat = i; break; end
    end
    if (!got) timeout("done");
    else begin
      start = 1'b1;
      cfg_num_rows = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", 64'(busy), 64'd0);
    end
    chk("req_ack_count", 64'(ack_cnt - a0), 64'(rows));
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    if (rows == 0) begin
      chk("empty_busy_cycles", 64'(busy_cnt - b0), 64'd1);
      chk("empty_done_latency", 64'(lat), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    bit got;
    rst = 1'b1; start = 1'b0; output_req = 1'b0; output_valid = 1'b0;
    output_mask = 4'h0; output_data = 32'h0; mem_wr_ready = 1'b1;
    cfg_base_addr = '0; cfg_row_stride = '0; cfg_num_rows = '0; cfg_valid_cols = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;

    rdy_mode = 0;
    run_job(16'h0100, 16'h0020, 2, 4'd10, 1);
    rdy_mode = 2;
    run_job(16'h0100, 16'h0020, 2, 4'd10, 1);
    rdy_mode = 0;
    run_job(16'h0000, 16'h0000, 0, 4'd3, 0);
    run_job(16'hFFF0, 16'h0010, 2, 4'd15, 2);
    rdy_mode = 1;
    for (int j = 0; j < 6; j++)
      run_job(AW'($urandom), AW'($urandom), $urandom_range(1, 4), 4'($urandom), 0);

    // Abort a job mid-stream with a write pending.
    rdy_mode = 3;
    @(posedge clk); #1;
    d0 = done_cnt;
    cfg_base_addr = 16'h0200; cfg_row_stride = 16'h0040; cfg_num_rows = 8'd2; cfg_valid_cols = 4'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    output_req = 1'b1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ack) begin got = 1; break; end
    end
    if (!got) timeout("abort_req_ack");
    @(posedge clk); #1;
    output_req = 1'b0;
    output_valid = 1'b1; output_mask = 4'hF; output_data = $urandom;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_wr_valid) begin got = 1; break; end
    end
    if (!got) timeout("abort_mem_wr_valid");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    output_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    chk("idle_after_abort", 64'(busy), 64'd0);
    @(posedge clk); #1;
    run_job(16'h0100, 16'h0020, 2, 4'd10, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
